tm1638_frame_ctrl: RTL and testbench

TM1638_FRAME_CTRL -- requirements
Module: tm1638_frame_ctrl

---
 rtl/tm1638_pkg.sv | 7 +
 rtl/seg7_encode.sv | 27 ++
 rtl/tm1638_frame_ctrl.sv | 88 ++++++++
 tb/tb_tm1638_frame_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/tm1638_pkg.sv
// tm1638_pkg: TM1638 command bytes and frame FSM states.
package tm1638_pkg;
  localparam logic [7:0] CMD_MODE_AUTO = 8'h40;
  localparam logic [7:0] CMD_ADDR0 = 8'hC0;
  localparam logic [4:0] CMD_DISP_ON = 5'b10001;
  typedef enum logic [2:0] {IDLE, CMD_MODE, CMD_ADDR, DATA, CMD_DISP} state_e;
endpackage

// File: rtl/seg7_encode.sv
// seg7_encode: hex digit to seven-segment pattern, bit order gfedcba.
module seg7_encode (
  input  logic [3:0] code_i,
  output logic [7:0] seg_o
);
  always_comb begin
    seg_o = 8'h00;
    case (code_i)
      4'h0: seg_o = 8'h3F;
      4'h1: seg_o = 8'h06;
      4'h2: seg_o = 8'h5B;
      4'h3: seg_o = 8'h4F;
      4'h4: seg_o = 8'h66;
      4'h5: seg_o = 8'h6D;
      4'h6: seg_o = 8'h7D;
      4'h7: seg_o = 8'h07;
      4'h8: seg_o = 8'h7F;
      4'h9: seg_o = 8'h6F;
      4'hA: seg_o = 8'h77;
      4'hB: seg_o = 8'h7C;
      4'hC: seg_o = 8'h39;
      4'hD: seg_o = 8'h5E;
      4'hE: seg_o = 8'h79;
      default: seg_o = 8'h71;
    endcase
  end
endmodule

// File: rtl/tm1638_frame_ctrl.sv
// tm1638_frame_ctrl: sequences one TM1638 display frame as 19 handshaked command/data bytes.
module tm1638_frame_ctrl
  import tm1638_pkg::*;
#(
  parameter logic [2:0] BRIGHT = 3'd7,
  parameter logic AUTO_REFRESH = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       refresh,
  input  logic [3:0] seg0,
  input  logic [3:0] seg1,
  input  logic [3:0] seg2,
  input  logic [3:0] seg3,
  input  logic [3:0] seg4,
  input  logic [3:0] seg5,
  input  logic [3:0] seg6,
  input  logic [3:0] seg7,
  input  logic [7:0] led,
  output logic [7:0] tx_byte,
  output logic       tx_valid,
  output logic       tx_last,
  input  logic       tx_ready,
  output logic       busy,
  output logic       frame_done
);
  state_e state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [31:0] seg_q;
  logic [7:0] led_q;
  logic done_q, accept, start;
  logic [7:0] enc;
  assign tx_valid = state_q != IDLE;
  assign busy = tx_valid;
  assign frame_done = done_q;
  assign accept = tx_valid & tx_ready;
  // a finishing frame can retrigger itself; a coincident refresh merges into the same start
  assign start = state_q == IDLE && (refresh || (AUTO_REFRESH && done_q));
  seg7_encode u_enc (.code_i(seg_q[{idx_q[3:1], 2'b00} +: 4]), .seg_o(enc));
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    tx_byte = 8'h00;
    tx_last = 1'b0;
    case (state_q)
      IDLE: state_d = start ? CMD_MODE : IDLE;
      CMD_MODE: begin
        tx_byte = CMD_MODE_AUTO;
        tx_last = 1'b1;
        state_d = accept ? CMD_ADDR : CMD_MODE;
      end
      CMD_ADDR: begin
        tx_byte = CMD_ADDR0;
        state_d = accept ? DATA : CMD_ADDR;
        idx_d = accept ? 4'd0 : idx_q;
      end
      DATA: begin
        tx_byte = idx_q[0] ? {7'd0, led_q[idx_q[3:1]]} : enc;
        tx_last = idx_q == 4'd15;
        state_d = (accept && tx_last) ? CMD_DISP : DATA;
        idx_d = (accept && !tx_last) ? idx_q + 4'd1 : idx_q;
      end
      CMD_DISP: begin
        tx_byte = {CMD_DISP_ON, BRIGHT};
        tx_last = 1'b1;
        state_d = accept ? IDLE : CMD_DISP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= 4'd0;
      seg_q <= 32'd0;
      led_q <= 8'd0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      done_q <= state_q == CMD_DISP && accept;
      if (start) begin
        seg_q <= {seg7, seg6, seg5, seg4, seg3, seg2, seg1, seg0};
        led_q <= led;
      end
    end
  end
endmodule

// File: tb/tb_tm1638_frame_ctrl.sv
// tb_tm1638_frame_ctrl: randomized frame checks of tm1638_frame_ctrl against a byte-list model.
module tb_tm1638_frame_ctrl;
  logic clk = 0, rst = 1, refresh = 0, ready = 0, sel = 0;
  logic [3:0] seg_in [8];
  logic [7:0] led_in;
  logic [7:0] byte0, byte1, m_byte;
  logic v0, v1, l0, l1, b0, b1, d0, d1, m_v, m_l, m_b, m_d;
  int n_vec = 0, n_err = 0;
  logic [7:0] seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
  logic [7:0] exp_f [19];
  logic [7:0] acc_b [$];
  logic acc_l [$];
  int done_cnt, done_at, acc18_at, busy_cnt;
  always #5 clk = ~clk;
  assign m_byte = sel ? byte1 : byte0;
  assign m_v = sel ? v1 : v0;
  assign m_l = sel ? l1 : l0;
  assign m_b = sel ? b1 : b0;
  assign m_d = sel ? d1 : d0;
  tm1638_frame_ctrl dut0 (
    .clk(clk), .rst(rst), .refresh(refresh),
    .seg0(seg_in[0]), .seg1(seg_in[1]), .seg2(seg_in[2]), .seg3(seg_in[3]),
    .seg4(seg_in[4]), .seg5(seg_in[5]), .seg6(seg_in[6]), .seg7(seg_in[7]),
    .led(led_in), .tx_byte(byte0), .tx_valid(v0), .tx_last(l0), .tx_ready(ready),
    .busy(b0), .frame_done(d0));
  tm1638_frame_ctrl #(.BRIGHT(3'd2), .AUTO_REFRESH(1'b1)) dut1 (
    .clk(clk), .rst(rst), .refresh(refresh),
    .seg0(seg_in[0]), .seg1(seg_in[1]), .seg2(seg_in[2]), .seg3(seg_in[3]),
    .seg4(seg_in[4]), .seg5(seg_in[5]), .seg6(seg_in[6]), .seg7(seg_in[7]),
    .led(led_in), .tx_byte(byte1), .tx_valid(v1), .tx_last(l1), .tx_ready(ready),
    .busy(b1), .frame_done(d1));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic void model(input logic [2:0] br);
    exp_f[0] = 8'h40;
    exp_f[1] = 8'hC0;
    for (int i = 0; i < 8; i++) begin
      exp_f[2 + 2 * i] = seg_tab[seg_in[i]];
      exp_f[3 + 2 * i] = {7'd0, led_in[i]};
    end
    exp_f[18] = 8'h88 + {5'd0, br};
  endfunction
  task automatic randomize_inputs();
    for (int i = 0; i < 8; i++) seg_in[i] = 4'($urandom);
    led_in = 8'($urandom);
  endtask
  task automatic run(input int budget, input bit rnd, input int ref_at, input int chg_at, input logic [2:0] br);
    logic [7:0] pb = 8'h00;
    bit ps = 0;
    acc_b.delete();
    acc_l.delete();
    done_cnt = 0;
    done_at = -1;
    acc18_at = -1;
    busy_cnt = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done_at >= 0 && c == done_at + 3) break;
      if (ps) begin
        check("stall_valid", m_v, 1);
        check("stall_byte", m_byte, pb);
      end
      if (c == 1) begin
        check("latency_valid", m_v, 1);
        check("latency_byte", m_byte, 8'h40);
      end
      if (m_d) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (m_b) busy_cnt++;
      if (c == 0) model(br);
      if (c == chg_at) randomize_inputs();
      refresh = (c == 0) || (c == ref_at);
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_v && ready) begin
        acc_b.push_back(m_byte);
        acc_l.push_back(m_l);
        if (acc_b.size() == 19) acc18_at = c;
      end
      ps = m_v && !ready;
      pb = m_byte;
    end
    refresh = 0;
  endtask
  task automatic verify(input int nbytes, input int nbusy);
    check("byte_count", acc_b.size(), nbytes);
    check("done_count", done_cnt, 1);
    check("done_timing", done_at, acc18_at + 1);
    for (int i = 0; i < 19 && i < acc_b.size(); i++) begin
      check("frame_byte", acc_b[i], exp_f[i]);
      check("frame_last", acc_l[i], (i == 0 || i >= 17) ? 1 : 0);
    end
    if (nbusy >= 0) check("busy_cycles", busy_cnt, nbusy);
  endtask
  initial begin
    int cnt, dn;
    for (int i = 0; i < 8; i++) seg_in[i] = 4'd0;
    led_in = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_valid", v0, 0);
    check("rst_byte", byte0, 0);
    check("rst_last", l0, 0);
    check("rst_busy", b0, 0);
    check("rst_done", d0, 0);
    refresh = 1;
    @(negedge clk);
    check("rst_priority", v0, 0);
    rst = 0;
    refresh = 0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) seg_in[i] = 4'(i);
    led_in = 8'hA5;
    run(100, 0, -1, -1, 3'd7);
    verify(19, 19);
    check("final_byte_8F", acc_b.size() == 19 ? acc_b[18] : 8'h00, 8'h8F);
    repeat (4) begin
      randomize_inputs();
      run(300, 1, -1, -1, 3'd7);
      verify(19, -1);
    end
    for (int i = 0; i < 8; i++) seg_in[i] = 4'(10 + i);
    run(300, 1, -1, 5, 3'd7);
    verify(19, -1);
    randomize_inputs();
    run(100, 0, 8, -1, 3'd7);
    verify(19, 19);
    randomize_inputs();
    model(3'd7);
    @(negedge clk);
    refresh = 1;
    ready = 1;
    cnt = 0;
    for (int c = 0; c < 40 && cnt < 9; c++) begin
      @(negedge clk);
      refresh = 0;
      if (v0 && cnt == 8) check("pre_rst_byte", byte0, exp_f[8]);
      if (v0) cnt++;
    end
    @(negedge clk);
    check("rst_reach", cnt, 9);
    check("pre_rst_idx7", byte0, exp_f[9]);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("abort_valid", v0, 0);
    check("abort_busy", b0, 0);
    check("abort_byte", byte0, 0);
    dn = 0;
    repeat (25) begin
      @(negedge clk);
      if (d0) dn++;
    end
    check("abort_no_done", dn, 0);
    randomize_inputs();
    run(100, 0, -1, -1, 3'd7);
    verify(19, 19);
    rst = 1;
    @(negedge clk);
    rst = 0;
    sel = 1;
    randomize_inputs();
    run(100, 0, -1, -1, 3'd2);
    verify(21, -1);
    check("bright2_byte", acc_b.size() >= 19 ? acc_b[18] : 8'h00, 8'h8A);
    check("auto_restart", acc_b.size() > 19 ? acc_b[19] : 8'h00, 8'h40);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
